// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory, execute-stage and redirect signals of the fetch stage
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic        redirect;
  logic [31:0] redirect_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instruction, pc, pcNext,
    input  instr_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instruction, pc, pcNext,
    output instr_ready, redirect, redirect_target
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, single-outstanding imem fetch and instruction buffer with redirect flush
// Optional perf counters: define FETCH_PERF_COUNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  stall_count
`endif
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] START_PC  = {RESET_PC[31:2], 2'b00};
  localparam logic [2:0]  DEPTH_W   = 3'(DEPTH);
  localparam logic [1:0]  LAST_SLOT = 2'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        req_q;
  logic [31:0] addr_q;

  logic [31:0] buf_pc   [4];
  logic [31:0] buf_word [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;

  logic        push;
  logic        pop;
  logic [2:0]  count_after;
  logic        room_after;
  logic [31:0] redirect_pc;
  logic [31:0] next_seq_pc;
  logic        head_valid;
  logic [31:0] head_pc;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    redirect_pc = bus.redirect_target & 32'hFFFF_FFFC;
    next_seq_pc = fetch_pc + 32'd4;
    push        = (state == WAIT) && bus.imem_ack && !bus.redirect;
    pop         = (count != 3'd0) && bus.instr_ready && !bus.redirect;
    count_after = count + {2'b00, push} - {2'b00, pop};
    // A redirect empties the buffer, so there is always room after it.
    room_after  = bus.redirect || (count_after < DEPTH_W);
    head_valid  = (count != 3'd0);
    head_pc     = head_valid ? buf_pc[rd_ptr] : fetch_pc;
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = head_valid;
  assign bus.instruction = head_valid ? buf_word[rd_ptr] : NOP;
  assign bus.pc          = head_pc;
  assign bus.pcNext      = head_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= START_PC;
      req_q    <= 1'b0;
      addr_q   <= START_PC;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc <= redirect_pc;
          end else if (count < DEPTH_W) begin
            state  <= WAIT;
            req_q  <= 1'b1;
            addr_q <= fetch_pc;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            fetch_pc <= redirect_pc;
            if (bus.imem_ack) addr_q <= redirect_pc;
            else              state  <= FLUSH;
          end else if (bus.imem_ack) begin
            fetch_pc <= next_seq_pc;
            if (room_after) begin
              addr_q <= next_seq_pc;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          // The stale request must still complete; its data is dropped.
          if (bus.redirect) fetch_pc <= redirect_pc;
          if (bus.imem_ack) begin
            if (room_after) begin
              state  <= WAIT;
              addr_q <= bus.redirect ? redirect_pc : fetch_pc;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else if (bus.redirect) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_after;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= fetch_pc;
      buf_word[wr_ptr] <= bus.imem_rdata;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (pop) fetch_count <= fetch_count + 32'd1;
      if (bus.instr_ready && !head_valid && !bus.redirect) stall_count <= stall_count + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if wbus ();

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fc, sc, wfc, wsc;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_PERF_COUNT_EN
        , .fetch_count(fc), .stall_count(sc)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(wbus)
`ifdef FETCH_PERF_COUNT_EN
        , .fetch_count(wfc), .stall_count(wsc)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    entry_t      mq[$];
    logic [31:0] m_fpc, m_addr;
    logic        m_pending, m_stale;
    logic [31:0] m_fetch, m_stall;

    int mem_fixed, mem_delay, ack_cnt, first_valid, cyc;
    logic [31:0] dlv[$];
    logic [31:0] wpc[$];
    logic [31:0] wnext[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic int next_delay();
        return (mem_fixed >= 0) ? mem_fixed : int'($urandom_range(3, 0));
    endfunction

    task automatic drive_idle();
        bus.imem_ack = 1'b0;  bus.imem_rdata = 32'd0;  bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;  bus.redirect_target = 32'd0;
        wbus.imem_ack = 1'b0; wbus.imem_rdata = 32'd0; wbus.instr_ready = 1'b0;
        wbus.redirect = 1'b0; wbus.redirect_target = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_valid", bus.instr_valid, 1'b0);
        check("rst_instr", bus.instruction, NOP);
        check("rst_pc", bus.pc, 32'h0000_0000);
        check("rst_pcnext", bus.pcNext, 32'h0000_0004);
        check("rst_wrap_pc", wbus.pc, 32'hFFFF_FFF8);
        check("rst_wrap_pcnext", wbus.pcNext, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_COUNT_EN
        check("rst_fetch_count", fc, 32'd0);
        check("rst_stall_count", sc, 32'd0);
`endif
        mq.delete();
        m_fpc = 32'd0; m_addr = 32'd0; m_pending = 1'b0; m_stale = 1'b0;
        m_fetch = 32'd0; m_stall = 32'd0;
        mem_delay = next_delay();
        ack_cnt = 0; first_valid = -1; cyc = 0;
        dlv.delete(); wpc.delete(); wnext.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic        ack, exp_v, acked;
        logic [31:0] rd, exp_pc, exp_in;
        int          occ0;
        entry_t      e;

        exp_v  = (mq.size() != 0);
        exp_pc = exp_v ? mq[0].pc : m_fpc;
        exp_in = exp_v ? mq[0].word : NOP;
        check("instr_valid", bus.instr_valid, exp_v);
        check("pc", bus.pc, exp_pc);
        check("pcNext", bus.pcNext, exp_pc + 32'd4);
        check("instruction", bus.instruction, exp_in);
        check("imem_req", bus.imem_req, m_pending);
        if (m_pending) check("imem_addr", bus.imem_addr, m_addr);
`ifdef FETCH_PERF_COUNT_EN
        check("fetch_count", fc, m_fetch);
        check("stall_count", sc, m_stall);
`endif
        if (bus.instr_valid && first_valid < 0) first_valid = cyc;

        ack = 1'b0;
        rd  = $urandom;
        if (bus.imem_req) begin
            if (mem_delay == 0) begin
                ack = 1'b1;
                rd = word_of(bus.imem_addr);
                mem_delay = next_delay();
                ack_cnt++;
            end else begin
                mem_delay--;
            end
        end
        bus.imem_ack = ack; bus.imem_rdata = rd; bus.instr_ready = rdy;
        bus.redirect = redir; bus.redirect_target = tgt;
        if (bus.instr_valid && rdy && !redir) dlv.push_back(bus.pc);

        occ0  = mq.size();
        acked = m_pending && ack;
        if (redir) begin
            mq.delete();
            m_fpc = tgt & 32'hFFFF_FFFC;
            if (acked) begin
                m_addr = m_fpc;
                m_stale = 1'b0;
            end else if (m_pending) begin
                m_stale = 1'b1;
            end
        end else begin
            if (rdy && occ0 > 0) begin
                void'(mq.pop_front());
                m_fetch = m_fetch + 32'd1;
            end
            if (rdy && occ0 == 0) m_stall = m_stall + 32'd1;
            if (acked) begin
                if (!m_stale) begin
                    e.pc = m_fpc; e.word = rd;
                    mq.push_back(e);
                    m_fpc = m_fpc + 32'd4;
                end
                m_stale = 1'b0;
                if (mq.size() < DEPTH) m_addr = m_fpc;
                else m_pending = 1'b0;
            end else if (!m_pending && occ0 < DEPTH) begin
                m_pending = 1'b1;
                m_addr = m_fpc;
            end
        end

        wbus.imem_ack = wbus.imem_req; wbus.imem_rdata = wbus.imem_addr;
        wbus.instr_ready = 1'b1; wbus.redirect = 1'b0; wbus.redirect_target = 32'd0;
        if (wbus.instr_valid) begin
            wpc.push_back(wbus.pc);
            wnext.push_back(wbus.pcNext);
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        mem_fixed = 0;
        @(negedge clk);

        mem_fixed = 0;
        do_reset();
        repeat (8) step(1'b1, 1'b0, 32'd0);
        check("a_first_valid_cycle", first_valid, 2);
        check("a_pc0", dlv[0], 32'h0);
        check("a_pc1", dlv[1], 32'h4);
        check("a_pc2", dlv[2], 32'h8);
        check("a_pc3", dlv[3], 32'hC);
        check("wrap_count_ok", wpc.size() >= 3, 1'b1);
        check("wrap_pc0", wpc[0], 32'hFFFF_FFF8);
        check("wrap_pc1", wpc[1], 32'hFFFF_FFFC);
        check("wrap_pc2", wpc[2], 32'h0000_0000);
        check("wrap_pcnext1", wnext[1], 32'h0000_0000);

        do_reset();
        repeat (8) step(1'b0, 1'b0, 32'd0);
        check("b_acks_while_stalled", ack_cnt, 2);
        check("b_req_low_when_full", bus.imem_req, 1'b0);
        repeat (6) step(1'b1, 1'b0, 32'd0);
        check("b_pc0", dlv[0], 32'h0);
        check("b_pc1", dlv[1], 32'h4);
        check("b_pc2", dlv[2], 32'h8);

        mem_fixed = 3;
        do_reset();
        repeat (10) step(1'b1, 1'b0, 32'd0);
        check("c_first_valid_cycle", first_valid, 5);
        check("c_pc0", dlv[0], 32'h0);

        mem_fixed = 2;
        do_reset();
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_0103);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("d_addr_after_flush", bus.imem_addr, 32'h0000_0100);
        repeat (8) step(1'b1, 1'b0, 32'd0);
        check("d_first_pc", dlv[0], 32'h0000_0100);

        mem_fixed = 0;
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_0040);
        check("e_valid_after_redirect", bus.instr_valid, 1'b0);
        repeat (6) step(1'b1, 1'b0, 32'd0);
        check("e_first_pc", dlv[0], 32'h0000_0040);

        mem_fixed = -1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
